// File: rtl/hfu_pkg.sv
// Shared encodings and shadow-entry layout for the hazard scoreboard.
// Build option HFU_SP_TRACK_EN adds a stack-pointer write bit to every entry.
package hfu_pkg;

  // Entries hold register addresses zero-extended to this width, so REG_AW must not exceed it.
  localparam int HFU_MAX_AW = 8;

  typedef enum logic [1:0] {
    KIND_ALU      = 2'd0,
    KIND_LOAD     = 2'd1,
    KIND_INPORT   = 2'd2,
    KIND_LOAD_ALT = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_IN  = 2'd3
  } fwd_e;

  typedef struct packed {
    logic                  v;
    logic                  we;
    logic [HFU_MAX_AW-1:0] dst;
    logic [1:0]            kind;
`ifdef HFU_SP_TRACK_EN
    logic                  sp_wr;
`endif
  } entry_t;

  function automatic logic is_load(input logic [1:0] kind);
    return (kind == KIND_LOAD) || (kind == KIND_LOAD_ALT);
  endfunction

endpackage

// File: rtl/hfu_src_match.sv
// Match flags and EX-stage forward select for one source operand
// against the EX and MEM shadow entries.
module hfu_src_match
  import hfu_pkg::*;
(
  input  logic                  i_used,
  input  logic [HFU_MAX_AW-1:0] i_src,
  input  logic                  i_ex_v,
  input  logic                  i_ex_w,
  input  logic [HFU_MAX_AW-1:0] i_ex_dst,
  input  logic [1:0]            i_ex_kind,
  input  logic                  i_mem_v,
  input  logic                  i_mem_w,
  input  logic [HFU_MAX_AW-1:0] i_mem_dst,
  input  logic [1:0]            i_mem_kind,
  output logic                  o_hazard,
  output logic [1:0]            o_fwd
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = i_used & i_ex_v & i_ex_w & (i_ex_dst == i_src);
  assign w_mem_hit = i_used & i_mem_v & i_mem_w & (i_mem_dst == i_src);

  // Only ALU results exist early enough to bypass from the instruction right ahead.
  assign o_hazard = w_ex_hit & (i_ex_kind != KIND_ALU);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_ex_hit) begin
      o_fwd = FWD_MEM;
    end else if (w_mem_hit) begin
      o_fwd = (i_mem_kind == KIND_INPORT) ? FWD_IN : FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: load-use stalls, load-latency wait,
// branch-flush handling and registered EX forwarding selects.
// Build option HFU_SP_TRACK_EN tracks the stack pointer as a virtual register.
module hazard_scoreboard
  import hfu_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int LOAD_LAT = 1   // legal range 1..4
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_dst,
  input  logic [1:0]        id_kind,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_ra_used,
  input  logic              id_rb_used,
  input  logic              flush,
`ifdef HFU_SP_TRACK_EN
  input  logic              id_sp_rd,
  input  logic              id_sp_wr,
  output logic [1:0]        fwd_sp,
`endif
  output logic              stall,
  output logic              ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [1:0] CNT_LOAD = 2'(LOAD_LAT - 1);

  entry_t     r_ex;
  entry_t     r_mem;
  entry_t     r_wb;
  logic [1:0] r_cnt;
  logic       r_flush_pend;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  entry_t     w_id_entry;
  entry_t     w_ex_to_mem;
  logic       w_hz_a;
  logic       w_hz_b;
  logic       w_hz_any;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_hazard;
  logic       w_mem_wait;
  logic       w_flush_eff;
  logic       w_capture;
  logic       w_unused_wb;

  hfu_src_match u_match_a (
    .i_used     (id_ra_used),
    .i_src      (HFU_MAX_AW'(id_ra)),
    .i_ex_v     (r_ex.v),
    .i_ex_w     (r_ex.we),
    .i_ex_dst   (r_ex.dst),
    .i_ex_kind  (r_ex.kind),
    .i_mem_v    (r_mem.v),
    .i_mem_w    (r_mem.we),
    .i_mem_dst  (r_mem.dst),
    .i_mem_kind (r_mem.kind),
    .o_hazard   (w_hz_a),
    .o_fwd      (w_fwd_a)
  );

  hfu_src_match u_match_b (
    .i_used     (id_rb_used),
    .i_src      (HFU_MAX_AW'(id_rb)),
    .i_ex_v     (r_ex.v),
    .i_ex_w     (r_ex.we),
    .i_ex_dst   (r_ex.dst),
    .i_ex_kind  (r_ex.kind),
    .i_mem_v    (r_mem.v),
    .i_mem_w    (r_mem.we),
    .i_mem_dst  (r_mem.dst),
    .i_mem_kind (r_mem.kind),
    .o_hazard   (w_hz_b),
    .o_fwd      (w_fwd_b)
  );

`ifdef HFU_SP_TRACK_EN
  logic       w_hz_sp;
  logic [1:0] w_fwd_sp;
  logic [1:0] r_fwd_sp;

  // The stack pointer behaves as one extra register with a fixed address.
  hfu_src_match u_match_sp (
    .i_used     (id_sp_rd),
    .i_src      ('0),
    .i_ex_v     (r_ex.v),
    .i_ex_w     (r_ex.sp_wr),
    .i_ex_dst   ('0),
    .i_ex_kind  (r_ex.kind),
    .i_mem_v    (r_mem.v),
    .i_mem_w    (r_mem.sp_wr),
    .i_mem_dst  ('0),
    .i_mem_kind (r_mem.kind),
    .o_hazard   (w_hz_sp),
    .o_fwd      (w_fwd_sp)
  );

  assign w_hz_any = w_hz_a | w_hz_b | w_hz_sp;
  assign fwd_sp   = r_fwd_sp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_sp <= FWD_RF;
    end else if (!w_mem_wait) begin
      r_fwd_sp <= w_capture ? w_fwd_sp : FWD_RF;
    end
  end
`else
  assign w_hz_any = w_hz_a | w_hz_b;
`endif

  assign w_hazard    = id_valid & w_hz_any;
  assign w_mem_wait  = (r_cnt != 2'd0);
  assign w_flush_eff = flush | r_flush_pend;
  assign w_capture   = ~w_mem_wait & id_valid & ~w_hazard & ~w_flush_eff;

  assign stall     = (w_hazard & ~w_flush_eff) | w_mem_wait;
  // An empty ID slot is already a bubble; only a refused valid instruction needs a NOP.
  assign ex_bubble = ~w_mem_wait & id_valid & ~w_capture;
  assign fwd_a     = r_fwd_a;
  assign fwd_b     = r_fwd_b;

  always_comb begin
    w_id_entry      = '0;
    w_id_entry.v    = w_capture;
    w_id_entry.we   = id_we;
    w_id_entry.dst  = HFU_MAX_AW'(id_dst);
    w_id_entry.kind = id_kind;
`ifdef HFU_SP_TRACK_EN
    w_id_entry.sp_wr = id_sp_wr;
`endif
    w_ex_to_mem   = r_ex;
    w_ex_to_mem.v = r_ex.v & ~w_flush_eff;
  end

  // WB is kept only as the tail of the shadow pipe; nothing downstream reads it.
  assign w_unused_wb = ^r_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex.v       <= 1'b0;
      r_mem.v      <= 1'b0;
      r_wb.v       <= 1'b0;
      r_cnt        <= 2'd0;
      r_flush_pend <= 1'b0;
      r_fwd_a      <= FWD_RF;
      r_fwd_b      <= FWD_RF;
    end else if (w_mem_wait) begin
      r_cnt        <= r_cnt - 2'd1;
      r_flush_pend <= r_flush_pend | flush;
    end else begin
      r_ex         <= w_id_entry;
      r_mem        <= w_ex_to_mem;
      r_wb         <= r_mem;
      r_cnt        <= (w_ex_to_mem.v && is_load(r_ex.kind)) ? CNT_LOAD : 2'd0;
      r_flush_pend <= 1'b0;
      r_fwd_a      <= w_capture ? w_fwd_a : FWD_RF;
      r_fwd_b      <= w_capture ? w_fwd_b : FWD_RF;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (LOAD_LAT 1 and 3) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid, id_we, id_ra_used, id_rb_used, flush;
  logic       id_sp_rd, id_sp_wr;
  logic [2:0] id_dst, id_ra, id_rb;
  logic [1:0] id_kind;

  logic       st_o[2];
  logic       bu_o[2];
  logic [1:0] fa_o[2];
  logic [1:0] fb_o[2];
`ifdef HFU_SP_TRACK_EN
  logic [1:0] fs_o[2];
`endif

  int n_chk = 0;
  int n_err = 0;

  hazard_scoreboard #(.REG_AW(3), .LOAD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_we(id_we), .id_dst(id_dst),
    .id_kind(id_kind), .id_ra(id_ra), .id_rb(id_rb), .id_ra_used(id_ra_used),
    .id_rb_used(id_rb_used), .flush(flush),
`ifdef HFU_SP_TRACK_EN
    .id_sp_rd(id_sp_rd), .id_sp_wr(id_sp_wr), .fwd_sp(fs_o[0]),
`endif
    .stall(st_o[0]), .ex_bubble(bu_o[0]), .fwd_a(fa_o[0]), .fwd_b(fb_o[0])
  );

  hazard_scoreboard #(.REG_AW(3), .LOAD_LAT(3)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_we(id_we), .id_dst(id_dst),
    .id_kind(id_kind), .id_ra(id_ra), .id_rb(id_rb), .id_ra_used(id_ra_used),
    .id_rb_used(id_rb_used), .flush(flush),
`ifdef HFU_SP_TRACK_EN
    .id_sp_rd(id_sp_rd), .id_sp_wr(id_sp_wr), .fwd_sp(fs_o[1]),
`endif
    .stall(st_o[1]), .ex_bubble(bu_o[1]), .fwd_a(fa_o[1]), .fwd_b(fb_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance: the instruction sitting in EX and in MEM, the remaining
  // load-wait cycles, a remembered flush, and the forward codes now in EX.
  typedef struct {
    bit v;
    bit we;
    int dst;
    int kind;
    bit spw;
  } ins_t;

  ins_t ex_q[2];
  ins_t mem_q[2];
  int   wait_q[2];
  bit   pend_q[2];
  int   efa[2], efb[2], efs[2];
  bit   exp_stall[2];
  bit   mdl_ok = 0;
  int   lat_of[2] = '{1, 3};

  function automatic bit writes(input ins_t i, input bit used, input int r, input bit sp);
    if (!used || !i.v) return 0;
    return sp ? i.spw : (i.we && i.dst == r);
  endfunction

  function automatic int src_code(input int k, input bit used, input int r, input bit sp);
    if (writes(ex_q[k], used, r, sp)) return 1;
    if (writes(mem_q[k], used, r, sp)) return (mem_q[k].kind == 2) ? 3 : 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit hz, mw, fe, cap;
      int na, nb, ns;
      if (rst) begin
        ex_q[k].v = 0; mem_q[k].v = 0; wait_q[k] = 0; pend_q[k] = 0;
        efa[k] = 0; efb[k] = 0; efs[k] = 0; exp_stall[k] = 0;
      end else if (mdl_ok) begin
        hz = id_valid && (ex_q[k].kind != 0) &&
             (writes(ex_q[k], id_ra_used, int'(id_ra), 0) ||
              writes(ex_q[k], id_rb_used, int'(id_rb), 0) ||
              writes(ex_q[k], id_sp_rd, 0, 1));
        mw  = wait_q[k] > 0;
        fe  = flush || pend_q[k];
        cap = !mw && id_valid && !hz && !fe;
        exp_stall[k] = (hz && !fe) || mw;
        chk($sformatf("u%0d.stall", k), 32'(st_o[k]), 32'(exp_stall[k]));
        chk($sformatf("u%0d.ex_bubble", k), 32'(bu_o[k]), 32'(!mw && id_valid && !cap));
        chk($sformatf("u%0d.fwd_a", k), 32'(fa_o[k]), efa[k]);
        chk($sformatf("u%0d.fwd_b", k), 32'(fb_o[k]), efb[k]);
`ifdef HFU_SP_TRACK_EN
        chk($sformatf("u%0d.fwd_sp", k), 32'(fs_o[k]), efs[k]);
`endif
        if (mw) begin
          wait_q[k]--;
          pend_q[k] = pend_q[k] || flush;
        end else begin
          na = src_code(k, id_ra_used, int'(id_ra), 0);
          nb = src_code(k, id_rb_used, int'(id_rb), 0);
          ns = src_code(k, id_sp_rd, 0, 1);
          efa[k] = cap ? na : 0;
          efb[k] = cap ? nb : 0;
          efs[k] = cap ? ns : 0;
          mem_q[k]   = ex_q[k];
          mem_q[k].v = ex_q[k].v && !fe;
          // kinds 1 and 3 are loads
          wait_q[k] = (mem_q[k].v && (mem_q[k].kind % 2 == 1)) ? lat_of[k] - 1 : 0;
          ex_q[k]   = '{cap, id_we, int'(id_dst), int'(id_kind), id_sp_wr};
          pend_q[k] = 0;
        end
      end
    end
    if (rst) mdl_ok = 1;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit we, input int dst, input int kind,
                       input int ra, input bit rau, input int rb, input bit rbu, input bit fl);
    @(posedge clk); #1;
    id_valid = v; id_we = we; id_dst = 3'(dst); id_kind = 2'(kind);
    id_ra = 3'(ra); id_ra_used = rau; id_rb = 3'(rb); id_rb_used = rbu;
    flush = fl; id_sp_rd = 0; id_sp_wr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Producer (optionally one unrelated instruction later) then a consumer held
  // in ID while stalled; measures stall length and the forward code in EX.
  task automatic pair(input string nm, input int kind, input int r, input bit use_a,
                      input bit gap, input int n0e, input int n1e, input int fe);
    int n[2];
    int f[2];
    bit done[2];
    bit b0[2];
    int ne[2];
    ne = '{n0e, n1e};
    n = '{0, 0}; f = '{-1, -1}; done = '{0, 0}; b0 = '{0, 0};
    idle(5);
    drive(1, 1, r, kind, 0, 0, 0, 0, 0);
    if (gap) drive(1, 1, 7, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 10 && !(done[0] && done[1]); c++) begin
      drive(1, 0, 0, 0, use_a ? r : 0, use_a, use_a ? 0 : r, !use_a, 0);
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (c == 0) b0[k] = bu_o[k];
        if (done[k] && f[k] < 0) f[k] = int'(use_a ? fa_o[k] : fb_o[k]);
        if (!done[k]) begin
          if (st_o[k]) n[k]++;
          else done[k] = 1;
        end
      end
    end
    chk({nm, ".stall_released"}, 32'(done[0] && done[1]), 1);
    idle(1);
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      if (f[k] < 0) f[k] = int'(use_a ? fa_o[k] : fb_o[k]);
      chk($sformatf("%s.u%0d.stall_cycles", nm, k), n[k], ne[k]);
      chk($sformatf("%s.u%0d.fwd", nm, k), f[k], fe);
      chk($sformatf("%s.u%0d.first_bubble", nm, k), 32'(b0[k]), 32'(ne[k] > 0));
    end
  endtask

  initial begin
    rst = 1; id_valid = 0; id_we = 0; id_dst = 0; id_kind = 0; id_ra = 0; id_rb = 0;
    id_ra_used = 0; id_rb_used = 0; flush = 0; id_sp_rd = 0; id_sp_wr = 0;
    exp_stall = '{0, 0};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset.u%0d.stall", k), 32'(st_o[k]), 0);
      chk($sformatf("reset.u%0d.ex_bubble", k), 32'(bu_o[k]), 0);
      chk($sformatf("reset.u%0d.fwd_a", k), 32'(fa_o[k]), 0);
      chk($sformatf("reset.u%0d.fwd_b", k), 32'(fb_o[k]), 0);
    end

    pair("alu_r1_ra",    0, 1, 1, 0, 0, 0, 1);
    pair("load_r2_rb",   1, 2, 0, 0, 1, 3, 2);
    pair("inport_gap",   2, 3, 1, 1, 0, 0, 3);
    pair("inport_b2b",   2, 3, 1, 0, 1, 1, 3);
    pair("kind3_r5_rb",  3, 5, 0, 0, 1, 3, 2);

    // flush raised while the LOAD_LAT=3 instance is waiting on a load
    idle(5);
    drive(1, 1, 4, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 6, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); #1;
    chk("flush.u1.stall_in_wait", 32'(st_o[1]), 1);
    chk("flush.u1.bubble_in_wait", 32'(bu_o[1]), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 6, 1, 0, 0, 0);
    @(negedge clk); #1;
    chk("flush.u1.stall_applied", 32'(st_o[1]), 0);
    chk("flush.u1.bubble_applied", 32'(bu_o[1]), 1);
    drive(1, 0, 0, 0, 6, 1, 0, 0, 0);
    @(negedge clk); #1;
    chk("flush.u1.fwd_a_killed_id", 32'(fa_o[1]), 0);
    idle(1);
    @(negedge clk); #1;
    chk("flush.u1.fwd_a_killed_ex", 32'(fa_o[1]), 0);

    // reset in the middle of a load wait
    idle(5);
    drive(1, 1, 2, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 2, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 2, 1, 0);
    @(negedge clk); #1;
    chk("rstwait.u1.stall_before", 32'(st_o[1]), 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; id_valid = 0; id_rb_used = 0;
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rstwait.u%0d.stall", k), 32'(st_o[k]), 0);
      chk($sformatf("rstwait.u%0d.fwd_a", k), 32'(fa_o[k]), 0);
      chk($sformatf("rstwait.u%0d.fwd_b", k), 32'(fb_o[k]), 0);
    end

    // random traffic; the ID instruction is held while the LAT=1 instance stalls
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (!exp_stall[0]) begin
        id_valid   = ($urandom_range(0, 3) != 0);
        id_we      = ($urandom_range(0, 4) != 0);
        id_dst     = 3'($urandom_range(0, 3));
        id_kind    = 2'($urandom_range(0, 3));
        id_ra      = 3'($urandom_range(0, 3));
        id_rb      = 3'($urandom_range(0, 3));
        id_ra_used = 1'($urandom_range(0, 1));
        id_rb_used = 1'($urandom_range(0, 1));
`ifdef HFU_SP_TRACK_EN
        id_sp_rd   = ($urandom_range(0, 2) == 0);
        id_sp_wr   = ($urandom_range(0, 2) == 0);
`endif
      end
    end
    @(posedge clk); #1 rst = 0; flush = 0; id_valid = 0;
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
